ps2_kbd_rx: RTL

- PS/2 keyboard receiver feeding the I/O space of the memory-mapped I/O bus.
- Deserialises 11-bit PS/2 frames, checks framing and parity, and buffers scan codes in a small FIFO.
- Presents the FIFO head as key_data with a ready flag. The bus returns these as {23'h0, ready, key_data} on a CPU load from 0xA000_0000–0xBFFF_FFFF.
- Pops one entry per read strobe on io_rdn (active low).

---
 rtl/ps2_pkg.sv | 22 ++
 rtl/ps2_kbd_rx_if.sv | 11 +
 rtl/ps2_fifo.sv | 51 +++++
 rtl/ps2_kbd_rx.sv | 126 ++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared constants, receiver state encoding and the frame validity rule
// for the PS/2 keyboard receiver.
package ps2_pkg;

  localparam int FRAME_BITS      = 11;
  localparam int START_BIT       = 0;
  localparam int PARITY_IDX      = 9;
  localparam int STOP_IDX        = 10;
  localparam int TIMEOUT_CYC_DEF = 50000;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    CHECK
  } rx_state_e;

  // Start low, stop high, odd parity across the data byte plus the parity bit.
  function automatic logic frame_ok(input logic [FRAME_BITS-1:0] f);
    return ~f[START_BIT] & f[STOP_IDX] & (^f[PARITY_IDX:START_BIT+1]);
  endfunction

endpackage

// File: rtl/ps2_kbd_rx_if.sv
// I/O-bus view of the keyboard receiver: read strobe in, scan code and flags out.
interface ps2_kbd_rx_if;
  logic       io_rdn;
  logic [7:0] key_data;
  logic       ready;
  logic       overflow;
  logic       frame_err;

  modport master (output io_rdn, input key_data, ready, overflow, frame_err);
  modport slave  (input io_rdn, output key_data, ready, overflow, frame_err);
endinterface

// File: rtl/ps2_fifo.sv
// Synchronous scan-code FIFO; a push while full is accepted only if a pop
// frees a slot on the same edge. Head reads as 8'h00 when empty.
module ps2_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? 8'h00 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage has no reset; validity is tracked by count, so clearing it buys nothing.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronises the PS/2 lines, deserialises and checks
// 11-bit frames, and queues good scan codes for the CPU to pop via io_rdn.
module ps2_kbd_rx
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ps2_clk,
  input  logic           ps2_data,
  ps2_kbd_rx_if.slave    bus
);
  localparam int TW = $clog2(TIMEOUT_CYC);

  logic [2:0]            clk_sync;
  logic [1:0]            dat_sync;
  logic                  rdn_q;
  logic                  fall;
  logic                  bit_in;
  logic                  pop;
  rx_state_e             state, state_n;
  logic [3:0]            cnt;
  logic [TW-1:0]         tcnt;
  logic [FRAME_BITS-1:0] frame;
  logic                  start, shift_en, set_err, push, timeout;
  logic                  overflow, frame_err;
  logic                  fifo_empty, fifo_full;
  logic [7:0]            fifo_dout;

  // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync <= '1;
      dat_sync <= '1;
      rdn_q    <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[1:0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
      rdn_q    <= bus.io_rdn;
    end
  end

  assign fall    = clk_sync[2] & ~clk_sync[1];
  assign bit_in  = dat_sync[1];
  assign pop     = rdn_q & ~bus.io_rdn;
  assign timeout = (tcnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
  always_comb begin
    state_n  = state;
    start    = 1'b0;
    shift_en = 1'b0;
    set_err  = 1'b0;
    push     = 1'b0;
    case (state)
      IDLE: begin
        if (fall) begin
          if (!bit_in) begin
            state_n = SHIFT;
            start   = 1'b1;
          end else begin
            set_err = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (fall) begin
          shift_en = 1'b1;
          if (cnt == 4'(STOP_IDX)) state_n = CHECK;
        end else if (timeout) begin
          state_n = IDLE;
          set_err = 1'b1;
        end
      end
      CHECK: begin
        state_n = IDLE;
        if (frame_ok(frame)) push    = 1'b1;
        else                 set_err = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  // Bits enter at the top so the start bit ends up in frame[0] after 11 shifts.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame     <= '0;
      cnt       <= '0;
      tcnt      <= '0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (start || shift_en) frame <= {bit_in, frame[FRAME_BITS-1:1]};
      if (start)             cnt   <= 4'd1;
      else if (shift_en)     cnt   <= cnt + 4'd1;
      if (state == SHIFT && !fall && !timeout) tcnt <= tcnt + TW'(1);
      else                                     tcnt <= '0;
      if (set_err)                           frame_err <= 1'b1;
      if (push && fifo_full && !pop)         overflow  <= 1'b1;
    end
  end

  ps2_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (frame[8:1]),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign bus.key_data  = fifo_dout;
  assign bus.ready     = ~fifo_empty;
  assign bus.overflow  = overflow;
  assign bus.frame_err = frame_err;

endmodule
